// File: rtl/line_buffer_window_ctrl.sv
// line_buffer_window_ctrl: accepts a raster pixel stream, feeds a WIN-tap line-buffer chain
// and flags when a complete WIN x WIN window is available with its centre coordinates.
module line_buffer_window_ctrl #(
  parameter int IMG_W = 684,
  parameter int IMG_H = 480,
  parameter int WIN   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic       lb_en,
  output logic [7:0] lb_din,
  output logic       win_valid,
  output logic [9:0] win_row,
  output logic [9:0] win_col,
  output logic       frame_done,
  output logic       sof_err
);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3;
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);
  localparam logic [9:0] EDGE = 10'(WIN - 1);
  localparam logic [9:0] HALF = 10'((WIN - 1) / 2);
  logic [1:0] state_q, state_d;
  logic [9:0] col_q, row_q, col_d, row_d;
  logic [9:0] pos_col, pos_row, nxt_col, nxt_row;
  logic       acc, last, win_hit;
  logic       lb_en_q, win_valid_q, sof_err_q;
  logic [7:0] lb_din_q;
  logic [9:0] win_row_q, win_col_q;
  // In IDLE only a start-of-frame pixel is taken; any accepted sof restarts at (0,0).
  always_comb begin
    in_ready = state_q != DONE;
    acc = in_valid & in_ready & ((state_q != IDLE) | in_sof);
    pos_col = in_sof ? 10'd0 : col_q;
    pos_row = in_sof ? 10'd0 : row_q;
    last = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
    nxt_col = (pos_col == LAST_COL) ? 10'd0 : pos_col + 10'd1;
    nxt_row = (pos_col == LAST_COL) ? pos_row + 10'd1 : pos_row;
    win_hit = acc && (pos_row >= EDGE) && (pos_col >= EDGE);
    state_d = (state_q == DONE) ? IDLE : !acc ? state_q : last ? DONE : (nxt_row >= EDGE) ? RUN : FILL;
    col_d = !acc ? col_q : last ? 10'd0 : nxt_col;
    row_d = !acc ? row_q : last ? 10'd0 : nxt_row;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      lb_en_q <= 1'b0;
      lb_din_q <= '0;
      win_valid_q <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      lb_en_q <= acc;
      if (acc) lb_din_q <= in_pix;
      win_valid_q <= win_hit;
      if (win_hit) win_row_q <= pos_row - HALF;
      if (win_hit) win_col_q <= pos_col - HALF;
      sof_err_q <= acc & in_sof & (state_q != IDLE);
    end
  end
  assign lb_en = lb_en_q;
  assign lb_din = lb_din_q;
  assign win_valid = win_valid_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
  assign frame_done = state_q == DONE;
  assign sof_err = sof_err_q;
endmodule

// File: tb/tb_line_buffer_window_ctrl.sv
// tb_line_buffer_window_ctrl: directed scenarios with random pixels/gaps checked against
// a linear-pixel-index reference model of the controller.
module tb_line_buffer_window_ctrl;
  localparam int W = 16, H = 10, WN = 7, HALF = (WN - 1) / 2;
  localparam int NWIN = (W - WN + 1) * (H - WN + 1);
  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic [7:0] in_pix;
  logic in_ready, lb_en, win_valid, frame_done, sof_err;
  logic [7:0] lb_din;
  logic [9:0] win_row, win_col;
  int vecs = 0, errs = 0;
  int n_wv, n_fd, n_err;
  bit m_active = 0, m_done = 0;
  int m_k = 0;
  int e_en, e_din, e_wv, e_wr, e_wc, e_err;

  line_buffer_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .in_ready(in_ready), .lb_en(lb_en), .lb_din(lb_din), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [7:0] p);
    bit a, nd;
    int idx, rr, cc;
    rst = r; in_valid = v; in_sof = s; in_pix = p;
    a = !r && v && !m_done && (m_active || s);
    nd = 0;
    if (r) begin
      m_active = 0; m_k = 0;
      e_en = 0; e_din = 0; e_wv = 0; e_wr = 0; e_wc = 0; e_err = 0;
    end else begin
      e_en = a; e_wv = 0; e_err = 0;
      if (a) begin
        idx = s ? 0 : m_k;
        rr = idx / W;
        cc = idx % W;
        e_din = p;
        e_err = s && m_active;
        if (rr >= WN - 1 && cc >= WN - 1) begin
          e_wv = 1; e_wr = rr - HALF; e_wc = cc - HALF;
        end
        if (idx == W * H - 1) begin
          nd = 1; m_active = 0; m_k = 0;
        end else begin
          m_active = 1; m_k = idx + 1;
        end
      end
    end
    m_done = nd;
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, !m_done);
    chk("frame_done", frame_done, m_done);
    chk("lb_en", lb_en, e_en);
    chk("lb_din", lb_din, e_din);
    chk("win_valid", win_valid, e_wv);
    chk("win_row", win_row, e_wr);
    chk("win_col", win_col, e_wc);
    chk("sof_err", sof_err, e_err);
    n_wv += int'(win_valid);
    n_fd += int'(frame_done);
    n_err += int'(sof_err);
  endtask

  task automatic frame(input bit gaps);
    for (int k = 0; k < W * H; k++) begin
      if (gaps) repeat ($urandom_range(1, 5)) step(0, 0, 1'($urandom), 8'($urandom));
      step(0, 1, k == 0, 8'($urandom));
    end
  endtask

  task automatic clr();
    n_wv = 0; n_fd = 0; n_err = 0;
  endtask

  initial begin
    clr();
    repeat (3) step(1, 1'($urandom), 1'($urandom), 8'($urandom));
    repeat (5) step(0, 1, 0, 8'($urandom));
    clr();
    frame(0);
    repeat (3) step(0, 0, 0, 8'($urandom));
    chk("full_win_count", n_wv, NWIN);
    chk("full_done_count", n_fd, 1);
    clr();
    frame(1);
    repeat (3) step(0, 0, 0, 8'($urandom));
    chk("gap_win_count", n_wv, NWIN);
    chk("gap_done_count", n_fd, 1);
    clr();
    for (int k = 0; k < 8 * W + 5; k++) step(0, 1, k == 0, 8'($urandom));
    frame(0);
    step(0, 0, 0, 8'($urandom));
    chk("inject_err_count", n_err, 1);
    chk("inject_done_count", n_fd, 1);
    chk("inject_win_count", n_wv, 2 * (W - WN + 1) + NWIN);
    clr();
    for (int k = 0; k < 5 * W + 5; k++) step(0, 1, k == 0, 8'($urandom));
    step(1, 1, 1'($urandom), 8'($urandom));
    repeat (3) step(0, 1, 0, 8'($urandom));
    chk("rst_done_count", n_fd, 0);
    chk("rst_err_count", n_err, 0);
    clr();
    for (int k = 0; k < W * H; k++) step(0, 1, k == 0, 8'($urandom));
    step(0, 1, 1, 8'($urandom));
    frame(0);
    step(0, 0, 0, 8'($urandom));
    chk("b2b_done_count", n_fd, 2);
    chk("b2b_win_count", n_wv, 2 * NWIN);
    chk("b2b_err_count", n_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
